hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V datapath (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in an internal scoreboard and produces forwarding selects for the ALU operands.
- Detects load-use hazards and inserts a one-cycle stall, and flushes wrong-path instructions when a branch resolves taken in EX.
- Keeps stall and flush performance counters.
- Sits beside the pipeline registers and drives their enable, bubble and flush controls.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).

Ports:
- clk  in  1  pipeline clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1_addr  in  5  Rs1 address of the ID instruction.
- id_rs2_addr  in  5  Rs2 address of the ID instruction.
- id_rs1_used  in  1  ID instruction reads Rs1.
- id_rs2_used  in  1  ID instruction reads Rs2 (R-type, branch, store).
- id_rd_addr  in  5  destination register of the ID instruction.
- id_reg_wr_en  in  1  ID instruction writes the register file.
- id_mem_rd_en  in  1  ID instruction is a load.
- ex_br_en  in  1  EX instruction is a branch.
- ex_br_taken  in  1  ALU branch condition for the EX instruction.
- pc_hold  out  1  hold the PC (no fetch advance).
- ifid_hold  out  1  hold the IF/ID register.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX (all write/read enables 0).
- pc_redirect  out  1  select the branch address for the next PC.
- fwd_a_sel  out  2  EX Rs1 operand source: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback value.
- fwd_b_sel  out  2  EX Rs2 operand source, same encoding as fwd_a_sel.
- stall_cnt  out  CNT_W  load-use stall cycles since reset.
- flush_cnt  out  CNT_W  taken-branch flushes since reset.

Behaviour:
Scoreboard
- Three registered entries: EX, MEM, WB. Each entry holds {valid, rd, wr_en, ld}.
- Every cycle: WB<=MEM and MEM<=EX.
- EX<={id_valid, id_rd_addr, id_reg_wr_en, id_mem_rd_en}, unless idex_bubble is 1; then EX<=0.
- An entry with rd==0 is never a hazard source.
- The register file is write-through, so the WB entry needs no forwarding.

Forwarding
- Computed at ID and registered into fwd_*_sel, so the selects are valid during the instruction's EX cycle.
- For each used source: if it matches the EX entry (valid, wr_en, rd!=0, not ld) -> 01.
- Else if it matches the MEM entry (valid, wr_en, rd!=0) -> 10.
- Else -> 00.
- The younger producer (EX entry) wins when both match.
- If idex_bubble is 1, the registered selects are 00.

Load-use FSM (states RUN, LU_STALL)
- RUN -> LU_STALL when id_valid, the EX entry is a valid load with rd!=0, and a used source matches that rd, and no flush occurs this cycle.
- In that cycle (combinational): pc_hold=1, ifid_hold=1, idex_bubble=1.
- LU_STALL: the held instruction is re-evaluated; the load is now in MEM, so the select becomes 10. Unconditional return to RUN.
- A back-to-back hazard re-enters LU_STALL on the next evaluation.

Branch flush
- When ex_br_en && ex_br_taken (combinational, same cycle): pc_redirect=1, ifid_flush=1, idex_bubble=1.
- pc_hold and ifid_hold are forced to 0.
- The FSM goes to RUN.
- Flush has priority over a simultaneous load-use stall; the stalled instruction is wrong-path and is discarded.
- ex_br_taken is ignored when ex_br_en=0.

Counters
- stall_cnt increments on each cycle a load-use stall is asserted.
- flush_cnt increments on each taken-branch cycle.
- Both saturate at all-ones.

Reset
- Applies immediately and asynchronously, including mid-stall.
- Scoreboard cleared; FSM=RUN; counters=0; fwd_*_sel=00.
- pc_hold, ifid_hold, ifid_flush, idex_bubble and pc_redirect all 0 while rst_n=0.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 back-to-back -> fwd_a_sel=01 in sub's EX cycle; no stall; stall_cnt=0.
- add x5,... ; nop ; or x7,x4,x5 -> fwd_b_sel=10 in or's EX cycle.
- ld x5,0(x1) then add x6,x5,x2 -> one cycle with pc_hold=ifid_hold=idex_bubble=1; next cycle fwd_a_sel=10; stall_cnt=1.
- Writer to x0 followed by a reader of x0 -> fwd selects 00, no stall.
- Taken branch in EX while ID holds a load-use consumer -> pc_redirect=ifid_flush=idex_bubble=1, pc_hold=0; flush_cnt=1; stall_cnt unchanged.
- rst_n=0 asserted during LU_STALL -> all control outputs 0 immediately, counters 0; after release the FSM is in RUN and the scoreboard is empty.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline control for a 5-stage RISC-V core. It tracks in-flight destinations,
// selects ALU forwarding, and handles load-use stalls and taken-branch flushes.
module hazard_fwd_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_reg_wr_en,
    input  logic             id_mem_rd_en,
    input  logic             ex_br_en,
    input  logic             ex_br_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pc_redirect,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       ld;
    } sb_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The register file is write-through, so the WB slot can never change a
    // decision; only the EX and MEM slots of the scoreboard are held.
    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;

    state_t state_q, state_d;

    logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_fwd_ok;
    logic mem_fwd_ok;
    logic ex_ld_src;
    logic br_flush;
    logic lu_hazard;
    logic lu_stall;
    logic bubble;

    logic [1:0][4:0] src_addr;
    logic [1:0]      src_used;
    logic [1:0][1:0] src_sel;
    logic [1:0]      src_ld_hit;

    // A load in EX cannot forward its ALU result; it is a stall source instead.
    assign ex_fwd_ok  = ex_q.valid && ex_q.wr_en && (ex_q.rd != 5'd0) && !ex_q.ld;
    assign mem_fwd_ok = mem_q.valid && mem_q.wr_en && (mem_q.rd != 5'd0);
    assign ex_ld_src  = ex_q.valid && ex_q.ld && (ex_q.rd != 5'd0);

    assign src_addr = {id_rs2_addr, id_rs1_addr};
    assign src_used = {id_rs2_used, id_rs1_used};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic hit_ex;
            logic hit_mem;

            assign hit_ex  = src_used[gi] && ex_fwd_ok  && (src_addr[gi] == ex_q.rd);
            assign hit_mem = src_used[gi] && mem_fwd_ok && (src_addr[gi] == mem_q.rd);

            // Younger producer in EX takes precedence over MEM.
            assign src_sel[gi]    = hit_ex ? 2'b01 : (hit_mem ? 2'b10 : 2'b00);
            assign src_ld_hit[gi] = src_used[gi] && ex_ld_src && (src_addr[gi] == ex_q.rd);
        end
    endgenerate

    always_comb begin
        br_flush  = ex_br_en && ex_br_taken;
        lu_hazard = id_valid && (state_q == RUN) && (|src_ld_hit);
        // A taken branch discards the would-be stalled instruction.
        lu_stall  = lu_hazard && !br_flush;
        bubble    = lu_stall || br_flush;

        state_d = state_q;
        case (state_q)
            RUN:      if (lu_stall) state_d = LU_STALL;
            LU_STALL: state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (br_flush) begin
            state_d = RUN;
        end

        mem_d = ex_q;
        if (bubble) begin
            ex_d = '0;
        end else begin
            ex_d = '{valid: id_valid, rd: id_rd_addr, wr_en: id_reg_wr_en, ld: id_mem_rd_en};
        end

        fwd_a_sel_d = bubble ? 2'b00 : src_sel[0];
        fwd_b_sel_d = bubble ? 2'b00 : src_sel[1];

        stall_cnt_d = stall_cnt_q;
        if (lu_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if (br_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            fwd_a_sel_q <= 2'b00;
            fwd_b_sel_q <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced low while reset is held, whatever the inputs do.
    assign pc_hold     = rst_n && lu_stall;
    assign ifid_hold   = rst_n && lu_stall;
    assign ifid_flush  = rst_n && br_flush;
    assign pc_redirect = rst_n && br_flush;
    assign idex_bubble = rst_n && bubble;

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: scenario tasks drive an ID/EX stream,
// queue the expected forwarding selects and compare them one cycle later.
module tb_hazard_fwd_ctrl;

    localparam int CNT_W = 4;

    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_redirect}
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid, id_rs1_used, id_rs2_used, id_reg_wr_en, id_mem_rd_en;
    logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic             ex_br_en, ex_br_taken;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_redirect;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0]       ctrl_w;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       tk;
        logic [4:0] ctrl;
        logic [1:0] fa;
        logic [1:0] fb;
    } step_t;

    logic [3:0] exp_q[$];
    logic [3:0] exp_sel;

    always #5 clk = ~clk;

    assign ctrl_w = {pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_redirect};

    hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_wr_en (id_reg_wr_en),
        .id_mem_rd_en (id_mem_rd_en),
        .ex_br_en     (ex_br_en),
        .ex_br_taken  (ex_br_taken),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pc_redirect  (pc_redirect),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    function automatic step_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic wr, input logic ld, input logic [4:0] ctrl,
                                 input logic [1:0] fa, input logic [1:0] fb);
        step_t s;
        s = '{v: v, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, wr: wr, ld: ld,
              br: 1'b0, tk: 1'b0, ctrl: ctrl, fa: fa, fb: fb};
        return s;
    endfunction

    function automatic step_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        return mk(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, ctrl, fa, fb);
    endfunction

    // I-type: rs2 field carries immediate bits, so it is present but unused.
    function automatic step_t alui(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f,
                                   input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        return mk(1'b1, rs1, rs2f, 1'b1, 1'b0, rd, 1'b1, 1'b0, ctrl, fa, fb);
    endfunction

    function automatic step_t lw(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        return mk(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, ctrl, fa, fb);
    endfunction

    function automatic step_t sw(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        return mk(1'b1, rs1, rs2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, ctrl, fa, fb);
    endfunction

    function automatic step_t bub(input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ctrl, fa, fb);
    endfunction

    function automatic step_t taken(input step_t s);
        step_t r;
        r = s;
        r.br = 1'b1;
        r.tk = 1'b1;
        return r;
    endfunction

    task automatic set_inputs(input step_t s);
        id_valid     = s.v;
        id_rs1_addr  = s.rs1;
        id_rs2_addr  = s.rs2;
        id_rs1_used  = s.u1;
        id_rs2_used  = s.u2;
        id_rd_addr   = s.rd;
        id_reg_wr_en = s.wr;
        id_mem_rd_en = s.ld;
        ex_br_en     = s.br;
        ex_br_taken  = s.tk;
    endtask

    task automatic drive_step(input string name, input int idx, input step_t s);
        set_inputs(s);
        exp_q.push_back({s.fa, s.fb});
        $display("%0t %s[%0d] v=%0b rs1=x%0d/%0b rs2=x%0d/%0b rd=x%0d wr=%0b ld=%0b br=%0b/%0b",
                 $time, name, idx, s.v, s.rs1, s.u1, s.rs2, s.u2, s.rd, s.wr, s.ld, s.br, s.tk);
    endtask

    task automatic do_reset();
        set_inputs(bub(C_NONE, 2'b00, 2'b00));
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        set_inputs(taken(alu(5'd6, 5'd5, 5'd2, C_NONE, 2'b00, 2'b00)));
        #2;
        n_checks++;
        if (ctrl_w !== C_NONE) $display("FAIL reset_ctrl got %b want %b", ctrl_w, C_NONE);
        else n_pass++;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL reset_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel});
        else n_pass++;
        n_checks++;
        if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== '0) $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_fwd_ex();
        step_t t[$];
        do_reset();
        t.push_back(alu(5'd5, 5'd1, 5'd2, C_NONE, 2'b00, 2'b00));  // add x5,x1,x2
        t.push_back(alu(5'd6, 5'd5, 5'd3, C_NONE, 2'b01, 2'b00));  // sub x6,x5,x3
        t.push_back(bub(C_NONE, 2'b00, 2'b00));
        foreach (t[i]) begin
            drive_step("fwd_ex", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL fwd_ex[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL fwd_ex[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (stall_cnt !== '0) $display("FAIL fwd_ex stall_cnt got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_fwd_mem();
        step_t t[$];
        do_reset();
        t.push_back(alu(5'd5, 5'd1, 5'd2, C_NONE, 2'b00, 2'b00));  // add x5
        t.push_back(bub(C_NONE, 2'b00, 2'b00));                    // nop
        t.push_back(alu(5'd7, 5'd4, 5'd5, C_NONE, 2'b00, 2'b10));  // or x7,x4,x5
        t.push_back(alu(5'd5, 5'd3, 5'd4, C_NONE, 2'b00, 2'b00));  // add x5,x3,x4
        t.push_back(alu(5'd7, 5'd5, 5'd5, C_NONE, 2'b01, 2'b01));  // EX beats MEM? only EX has x5 here
        t.push_back(bub(C_NONE, 2'b00, 2'b00));
        t.push_back(alu(5'd8, 5'd4, 5'd5, C_NONE, 2'b00, 2'b00));  // x5 producer now in WB
        t.push_back(alui(5'd9, 5'd8, 5'd8, C_NONE, 2'b01, 2'b00)); // unused rs2 field
        foreach (t[i]) begin
            drive_step("fwd_mem", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL fwd_mem[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL fwd_mem[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        step_t t[$];
        do_reset();
        t.push_back(alu(5'd5, 5'd1, 5'd2, C_NONE, 2'b00, 2'b00));  // add x5 (older)
        t.push_back(alu(5'd5, 5'd3, 5'd4, C_NONE, 2'b00, 2'b00));  // add x5 (younger)
        t.push_back(alu(5'd7, 5'd5, 5'd5, C_NONE, 2'b01, 2'b01));  // both match: EX wins
        foreach (t[i]) begin
            drive_step("priority", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL priority[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL priority[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        step_t t[$];
        do_reset();
        t.push_back(lw(5'd5, 5'd1, C_NONE, 2'b00, 2'b00));          // ld x5,0(x1)
        t.push_back(alu(5'd6, 5'd5, 5'd2, C_STALL, 2'b00, 2'b00));  // add x6,x5,x2 stalls
        t.push_back(alu(5'd6, 5'd5, 5'd2, C_NONE, 2'b10, 2'b00));   // held, load now in MEM
        t.push_back(bub(C_NONE, 2'b00, 2'b00));
        foreach (t[i]) begin
            drive_step("load_use", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL load_use[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL load_use[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (stall_cnt !== 4'd1) $display("FAIL load_use stall_cnt got %0d want 1", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        step_t t[$];
        do_reset();
        t.push_back(lw(5'd5, 5'd1, C_NONE, 2'b00, 2'b00));           // ld x5
        t.push_back(lw(5'd6, 5'd5, C_STALL, 2'b00, 2'b00));          // ld x6,0(x5)
        t.push_back(lw(5'd6, 5'd5, C_NONE, 2'b10, 2'b00));           // held
        t.push_back(sw(5'd2, 5'd6, C_STALL, 2'b00, 2'b00));          // sw x6,0(x2)
        t.push_back(sw(5'd2, 5'd6, C_NONE, 2'b00, 2'b10));           // held
        t.push_back(bub(C_NONE, 2'b00, 2'b00));
        foreach (t[i]) begin
            drive_step("back_to_back", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL back_to_back[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL back_to_back[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (stall_cnt !== 4'd2) $display("FAIL back_to_back stall_cnt got %0d want 2", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_x0();
        step_t t[$];
        do_reset();
        t.push_back(alu(5'd0, 5'd1, 5'd2, C_NONE, 2'b00, 2'b00));  // add x0,x1,x2
        t.push_back(alu(5'd6, 5'd0, 5'd0, C_NONE, 2'b00, 2'b00));  // reads x0
        t.push_back(lw(5'd0, 5'd1, C_NONE, 2'b00, 2'b00));         // ld x0
        t.push_back(alu(5'd7, 5'd0, 5'd0, C_NONE, 2'b00, 2'b00));  // no load-use on x0
        t.push_back(alu(5'd8, 5'd0, 5'd0, C_NONE, 2'b00, 2'b00));  // ld x0 now in MEM
        foreach (t[i]) begin
            drive_step("x0", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL x0[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL x0[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (stall_cnt !== '0) $display("FAIL x0 stall_cnt got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        step_t t[$];
        do_reset();
        t.push_back(lw(5'd5, 5'd1, C_NONE, 2'b00, 2'b00));                  // ld x5
        t.push_back(taken(alu(5'd6, 5'd5, 5'd2, C_FLUSH, 2'b00, 2'b00)));   // flush beats stall
        t.push_back(alu(5'd8, 5'd5, 5'd5, C_NONE, 2'b10, 2'b10));           // fresh, load in MEM
        t.push_back(bub(C_NONE, 2'b00, 2'b00));
        t[3].tk = 1'b1;                                                      // taken without br_en
        t.push_back(taken(bub(C_FLUSH, 2'b00, 2'b00)));
        foreach (t[i]) begin
            drive_step("flush", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL flush[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL flush[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (flush_cnt !== 4'd2) $display("FAIL flush flush_cnt got %0d want 2", flush_cnt);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== '0) $display("FAIL flush stall_cnt got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        step_t t[$];
        step_t u[$];
        do_reset();
        t.push_back(lw(5'd5, 5'd1, C_NONE, 2'b00, 2'b00));
        t.push_back(alu(5'd6, 5'd5, 5'd2, C_STALL, 2'b00, 2'b00));
        foreach (t[i]) begin
            drive_step("rst_stall", i, t[i]);
            #1;
            n_checks++;
            if (ctrl_w !== t[i].ctrl) $display("FAIL rst_stall[%0d] ctrl got %b want %b", i, ctrl_w, t[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL rst_stall[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        // Now in LU_STALL with stall_cnt=1; hit reset with a flush request present.
        set_inputs(taken(alu(5'd6, 5'd5, 5'd2, C_NONE, 2'b00, 2'b00)));
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctrl_w !== C_NONE) $display("FAIL rst_stall in_reset ctrl got %b want %b", ctrl_w, C_NONE);
        else n_pass++;
        n_checks++;
        if ({stall_cnt, flush_cnt} !== 8'h00) $display("FAIL rst_stall counters got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        rst_n = 1'b1;
        u.push_back(alu(5'd6, 5'd5, 5'd2, C_NONE, 2'b00, 2'b00));    // scoreboard empty
        u.push_back(lw(5'd9, 5'd1, C_NONE, 2'b00, 2'b00));
        u.push_back(alu(5'd10, 5'd9, 5'd6, C_STALL, 2'b00, 2'b00));  // FSM back in RUN
        u.push_back(alu(5'd10, 5'd9, 5'd6, C_NONE, 2'b10, 2'b00));   // x6 producer in WB
        foreach (u[i]) begin
            drive_step("rst_after", i, u[i]);
            #1;
            n_checks++;
            if (ctrl_w !== u[i].ctrl) $display("FAIL rst_after[%0d] ctrl got %b want %b", i, ctrl_w, u[i].ctrl);
            else n_pass++;
            @(posedge clk); #1;
            exp_sel = exp_q.pop_front();
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== exp_sel) $display("FAIL rst_after[%0d] sel got %b want %b", i, {fwd_a_sel, fwd_b_sel}, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (stall_cnt !== 4'd1) $display("FAIL rst_after stall_cnt got %0d want 1", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_inputs(taken(bub(C_NONE, 2'b00, 2'b00)));
            @(posedge clk); #1;
            $display("%0t sat_flush[%0d] flush_cnt=%0d", $time, i, flush_cnt);
            if (i == 9) begin
                n_checks++;
                if (flush_cnt !== 4'd10) $display("FAIL sat_flush mid got %0d want 10", flush_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if (flush_cnt !== 4'd15) $display("FAIL sat_flush end got %0d want 15", flush_cnt);
        else n_pass++;
        for (int i = 0; i < 17; i++) begin
            set_inputs(lw(5'd5, 5'd1, C_NONE, 2'b00, 2'b00));
            @(posedge clk); #1;
            set_inputs(alu(5'd6, 5'd5, 5'd2, C_STALL, 2'b00, 2'b00));
            @(posedge clk); #1;
            @(posedge clk); #1;
            $display("%0t sat_stall[%0d] stall_cnt=%0d", $time, i, stall_cnt);
        end
        n_checks++;
        if (stall_cnt !== 4'd15) $display("FAIL sat_stall end got %0d want 15", stall_cnt);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== 4'd15) $display("FAIL sat_stall flush_cnt got %0d want 15", flush_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_x0();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
